// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Resolves load-use, EXE redirects and data-memory waits, and freezes the
// core when a memory access hangs for too long.
//
// Ports:
//   clk_i, rst_ni          core clock, async active-low reset
//   id_rs*_addr_i/used_i   source registers read by the ID instruction
//   exe_rd_addr_i/we_i     destination of the EXE instruction
//   exe_mem_re_i           EXE instruction is a load
//   exe_redirect_i         EXE resolved a taken branch/jump
//   mem_req_i/mem_ready_i  MEM stage access and its completion
//   pc_stall_o             hold the PC
//   *_mode_o               {stall, flush} per pipeline register
//   mem_timeout_o          sticky hung-memory flag
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds three saturating
// performance counters (perf_stall_cnt_o, perf_flush_cnt_o,
// perf_luse_cnt_o), each CNT_W bits wide.

`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [`GPR_ADDR_SPACE] id_rs1_addr_i,
   input  logic                   id_rs1_used_i,
   input  logic [`GPR_ADDR_SPACE] id_rs2_addr_i,
   input  logic                   id_rs2_used_i,
   input  logic [`GPR_ADDR_SPACE] exe_rd_addr_i,
   input  logic                   exe_rd_we_i,
   input  logic                   exe_mem_re_i,
   input  logic                   exe_redirect_i,
   input  logic                   mem_req_i,
   input  logic                   mem_ready_i,
   output logic                   pc_stall_o,
   output logic [1:0]             if_id_mode_o,
   output logic [1:0]             id_exe_mode_o,
   output logic [1:0]             exe_mem_mode_o,
   output logic [1:0]             mem_wb_mode_o,
   output logic                   mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]       perf_stall_cnt_o,
   output logic [CNT_W-1:0]       perf_flush_cnt_o,
   output logic [CNT_W-1:0]       perf_luse_cnt_o
`endif
);

   localparam int WCW = 10;

   localparam logic [1:0] M_RUN   = 2'b00;
   localparam logic [1:0] M_FLUSH = 2'b01;
   localparam logic [1:0] M_STALL = 2'b10;

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM_WAIT,
      S_FROZEN
   } state_t;

   state_t           r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic             r_timeout;

   logic w_mem_wait;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_load_use;
   logic w_active;
   logic w_redir_act;
   logic w_luse_act;

   assign w_mem_wait = mem_req_i & ~mem_ready_i;

   assign w_rs1_hit = id_rs1_used_i & (id_rs1_addr_i == exe_rd_addr_i);
   assign w_rs2_hit = id_rs2_used_i & (id_rs2_addr_i == exe_rd_addr_i);

   assign w_load_use = exe_mem_re_i & exe_rd_we_i
                     & (exe_rd_addr_i != '0)
                     & (w_rs1_hit | w_rs2_hit);

   // A redirect seen during a wait stays in the stalled EXE stage, so it
   // is only acted on once the wait has cleared.
   assign w_active    = (r_state != S_FROZEN);
   assign w_redir_act = w_active & ~w_mem_wait & exe_redirect_i;
   assign w_luse_act  = w_active & ~w_mem_wait & ~exe_redirect_i
                      & w_load_use;

   always_comb begin
      pc_stall_o     = 1'b0;
      if_id_mode_o   = M_RUN;
      id_exe_mode_o  = M_RUN;
      exe_mem_mode_o = M_RUN;
      mem_wb_mode_o  = M_RUN;
      if (!rst_ni) begin
         if_id_mode_o   = M_FLUSH;
         id_exe_mode_o  = M_FLUSH;
         exe_mem_mode_o = M_FLUSH;
         mem_wb_mode_o  = M_FLUSH;
      end else if (!w_active) begin
         pc_stall_o     = 1'b1;
         if_id_mode_o   = M_STALL;
         id_exe_mode_o  = M_STALL;
         exe_mem_mode_o = M_STALL;
         mem_wb_mode_o  = M_STALL;
      end else if (w_mem_wait) begin
         // Upstream holds, WB receives a bubble.
         pc_stall_o     = 1'b1;
         if_id_mode_o   = M_STALL;
         id_exe_mode_o  = M_STALL;
         exe_mem_mode_o = M_STALL;
         mem_wb_mode_o  = M_FLUSH;
      end else if (w_redir_act) begin
         if_id_mode_o   = M_FLUSH;
         id_exe_mode_o  = M_FLUSH;
      end else if (w_luse_act) begin
         pc_stall_o     = 1'b1;
         if_id_mode_o   = M_STALL;
         id_exe_mode_o  = M_FLUSH;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               if (w_mem_wait) begin
                  r_state    <= S_MEM_WAIT;
                  r_wait_cnt <= WCW'(1);
               end
            end
            S_MEM_WAIT: begin
               if (!w_mem_wait) begin
                  r_state    <= S_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WCW'(MEM_TIMEOUT)) begin
                  r_state   <= S_FROZEN;
                  r_timeout <= 1'b1;
               end else if (r_wait_cnt != '1) begin
                  r_wait_cnt <= r_wait_cnt + WCW'(1);
               end
            end
            S_FROZEN: begin
               r_state <= S_FROZEN;
            end
            default: begin
               r_state    <= S_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign mem_timeout_o = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_luse_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_luse_cnt  <= '0;
      end else if (w_active) begin
         if (pc_stall_o && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redir_act && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (w_luse_act && (r_luse_cnt != '1))
            r_luse_cnt <= r_luse_cnt + CNT_W'(1);
      end
   end

   assign perf_stall_cnt_o = r_stall_cnt;
   assign perf_flush_cnt_o = r_flush_cnt;
   assign perf_luse_cnt_o  = r_luse_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed scenarios plus random traffic against a behavioural model.

module tb_pipeline_hazard_ctrl;

   localparam int TO = 4;

   typedef struct packed {
      logic [4:0] rs1;
      logic       rs1u;
      logic [4:0] rs2;
      logic       rs2u;
      logic [4:0] rd;
      logic       we;
      logic       re;
      logic       redir;
      logic       req;
      logic       rdy;
   } stim_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   stim_t cur = '0;

   logic       pc_stall;
   logic [1:0] if_id, id_exe, exe_mem, mem_wb;
   logic       timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] p_stall, p_flush, p_luse;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   bit m_frozen  = 0;
   int m_waitlen = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .id_rs1_addr_i  (cur.rs1),
      .id_rs1_used_i  (cur.rs1u),
      .id_rs2_addr_i  (cur.rs2),
      .id_rs2_used_i  (cur.rs2u),
      .exe_rd_addr_i  (cur.rd),
      .exe_rd_we_i    (cur.we),
      .exe_mem_re_i   (cur.re),
      .exe_redirect_i (cur.redir),
      .mem_req_i      (cur.req),
      .mem_ready_i    (cur.rdy),
      .pc_stall_o     (pc_stall),
      .if_id_mode_o   (if_id),
      .id_exe_mode_o  (id_exe),
      .exe_mem_mode_o (exe_mem),
      .mem_wb_mode_o  (mem_wb),
      .mem_timeout_o  (timeout)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cnt_o (p_stall),
      .perf_flush_cnt_o (p_flush),
      .perf_luse_cnt_o  (p_luse)
`endif
   );

   function automatic stim_t mk(input logic [4:0] rs1, input logic rs1u,
                                input logic [4:0] rs2, input logic rs2u,
                                input logic [4:0] rd, input logic we,
                                input logic re, input logic redir,
                                input logic req, input logic rdy);
      stim_t s;
      s.rs1 = rs1; s.rs1u = rs1u; s.rs2 = rs2; s.rs2u = rs2u;
      s.rd = rd; s.we = we; s.re = re; s.redir = redir;
      s.req = req; s.rdy = rdy;
      return s;
   endfunction

   function automatic logic [9:0] dut_word();
      return {pc_stall, if_id, id_exe, exe_mem, mem_wb, timeout};
   endfunction

   // Spec rules: {pc_stall, IF_ID, ID_EXE, EXE_MEM, MEM_WB, timeout}
   function automatic logic [9:0] exp_word();
      bit mw, luse;
      mw   = cur.req && !cur.rdy;
      luse = cur.re && cur.we && (cur.rd != 0) &&
             ((cur.rs1u && cur.rs1 == cur.rd) ||
              (cur.rs2u && cur.rs2 == cur.rd));
      if (!rst_n)    return 10'b0_01_01_01_01_0;
      if (m_frozen)  return 10'b1_10_10_10_10_1;
      if (mw)        return 10'b1_10_10_10_01_0;
      if (cur.redir) return 10'b0_01_01_00_00_0;
      if (luse)      return 10'b1_10_01_00_00_0;
      return 10'b0;
   endfunction

   // Freeze once more than TO consecutive wait cycles have been seen.
   task automatic model_step();
      if (!m_frozen) begin
         if (cur.req && !cur.rdy) begin
            if (m_waitlen + 1 > TO) m_frozen = 1;
            else m_waitlen++;
         end else begin
            m_waitlen = 0;
         end
      end
   endtask

   task automatic do_reset();
      cur = '0;
      rst_n = 1'b0;
      #2;
      m_frozen = 0;
      m_waitlen = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (dut_word() !== 10'b0_01_01_01_01_0) begin
         n_fail++;
         $display("FAIL reset got %b exp %b", dut_word(), 10'b0_01_01_01_01_0);
      end else n_pass++;
      do_reset();
   endtask

   task automatic test_load_use();
      stim_t q[$];
      q.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      q.push_back(mk(1, 1, 7, 1, 7, 1, 1, 0, 0, 0));
      q.push_back(mk(7, 0, 3, 1, 7, 1, 1, 0, 0, 0));
      q.push_back(mk(7, 1, 3, 1, 7, 0, 1, 0, 0, 0));
      q.push_back(mk(7, 1, 3, 1, 7, 1, 0, 0, 0, 0));
      foreach (q[i]) begin
         cur = q[i];
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL load_use[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_redirect_priority();
      stim_t q[$];
      q.push_back(mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         cur = q[i];
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL redirect[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mem_wait();
      stim_t q[$];
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         cur = q[i];
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL mem_wait[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_timeout();
      stim_t q[$];
      for (int k = 0; k < TO + 3; k++)
         q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(mk(5, 1, 0, 0, 5, 1, 1, 1, 1, 1));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         cur = q[i];
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL timeout[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
      end
      n_chk++;
      if (timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_flag got %b exp 1", timeout);
      end else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (dut_word() !== 10'b0_01_01_01_01_0) begin
         n_fail++;
         $display("FAIL timeout_reset got %b exp %b", dut_word(), 10'b0_01_01_01_01_0);
      end else n_pass++;
      do_reset();
   endtask

   task automatic test_async_reset();
      stim_t q[$];
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
         model_step();
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (dut_word() !== 10'b0_01_01_01_01_0) begin
         n_fail++;
         $display("FAIL async_reset got %b exp %b", dut_word(), 10'b0_01_01_01_01_0);
      end else n_pass++;
      do_reset();
      // A fresh wait must again last TO+1 cycles before freezing.
      for (int k = 0; k < TO + 2; k++)
         q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      foreach (q[i]) begin
         cur = q[i];
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL post_reset[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cur.rs1   = 5'($urandom_range(0, 3));
         cur.rs1u  = 1'($urandom);
         cur.rs2   = 5'($urandom_range(0, 3));
         cur.rs2u  = 1'($urandom);
         cur.rd    = 5'($urandom_range(0, 3));
         cur.we    = 1'($urandom);
         cur.re    = 1'($urandom);
         cur.redir = ($urandom_range(0, 3) == 0);
         cur.req   = 1'($urandom);
         cur.rdy   = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         n_chk++;
         if (dut_word() !== exp_word()) begin
            n_fail++;
            $display("FAIL random[%0d] got %b exp %b", i, dut_word(), exp_word());
         end else n_pass++;
         model_step();
         @(posedge clk);
         #1;
         if (m_frozen && ($urandom_range(0, 3) == 0)) do_reset();
      end
      do_reset();
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      stim_t q[$];
      q.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0));
      q.push_back(mk(0, 0, 6, 1, 6, 1, 1, 0, 0, 0));
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      do_reset();
      foreach (q[i]) begin
         cur = q[i];
         @(posedge clk);
         #1;
      end
      n_chk++;
      if ({p_stall, p_luse, p_flush} !== {32'd5, 32'd2, 32'd1}) begin
         n_fail++;
         $display("FAIL perf got %0d/%0d/%0d exp 5/2/1", p_stall, p_luse, p_flush);
      end else n_pass++;
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_redirect_priority();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      test_random();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline.
- Generates the 2-bit mode word ({stall, flush}) for every pipeline register (IF_ID, ID_EXE, EXE_MEM, MEM_WB) plus a PC hold.
- Resolves load-use hazards, EXE-stage control-flow redirects and multi-cycle data-memory waits; includes a watchdog that freezes the core on a hung memory access.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM wait cycles before the core is frozen; valid range 1..1023
- CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  `GPR_ADDR_SPACE  rs1 index of the instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_addr_i  in  `GPR_ADDR_SPACE  rs2 index of the instruction in ID
- id_rs2_used_i  in  1  ID instruction reads rs2
- exe_rd_addr_i  in  `GPR_ADDR_SPACE  rd of the instruction in EXE
- exe_rd_we_i  in  1  EXE instruction writes rd
- exe_mem_re_i  in  1  EXE instruction is a load
- exe_redirect_i  in  1  EXE resolved a taken branch or jump
- mem_req_i  in  1  MEM stage holds a load or store (mem_re_o | mem_we_o of EXE_MEM)
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_stall_o  out  1  hold the PC
- if_id_mode_o  out  2  {stall, flush} for IF_ID
- id_exe_mode_o  out  2  {stall, flush} for ID_EXE
- exe_mem_mode_o  out  2  {stall, flush} for EXE_MEM
- mem_wb_mode_o  out  2  {stall, flush} for MEM_WB
- mem_timeout_o  out  1  sticky hung-memory flag

Behaviour:
- Mode encoding: bit1 = stall (hold), bit0 = flush (zero). The pipeline registers give stall precedence; the controller never drives 2'b11.
- Mode outputs are combinational from the current state and inputs, so the pipeline registers act on them at the same clock edge.
- FSM states:
  - S_RUN (reset state)
  - S_MEM_WAIT
  - S_FROZEN
- Reset (rst_ni low, asynchronous): state = S_RUN, wait_cnt = 0, mem_timeout_o = 0. While reset is asserted, all mode outputs = 2'b01 and pc_stall_o = 0.
- mem_wait = mem_req_i & ~mem_ready_i.
- Load-use: load_use = exe_mem_re_i & exe_rd_we_i & (exe_rd_addr_i != 0) & ((id_rs1_used_i & rs1 == exe_rd) | (id_rs2_used_i & rs2 == exe_rd)).
- Priority, evaluated each cycle in S_RUN or S_MEM_WAIT, first match wins:
  1. mem_wait: pc_stall = 1; IF_ID, ID_EXE and EXE_MEM = 2'b10; MEM_WB = 2'b01 (bubble into WB).
  2. exe_redirect_i: IF_ID = 01 and ID_EXE = 01; others 00; pc_stall = 0, since the PC loads the target. A redirect raised during a wait is held by the stalled EXE stage and acted on in the first cycle after the wait.
  3. load_use: pc_stall = 1; IF_ID = 10; ID_EXE = 01; others 00. Lasts exactly one cycle, because the load then moves to MEM.
  4. Otherwise all 00, pc_stall = 0.
- Transitions:
  - S_RUN -> S_MEM_WAIT when mem_wait; wait_cnt <= 1.
  - S_MEM_WAIT stays while mem_wait, with wait_cnt incrementing.
  - S_MEM_WAIT -> S_RUN when mem_ready_i; wait_cnt <= 0. Outputs in that cycle follow priority 2-4.
  - S_MEM_WAIT -> S_FROZEN when mem_wait and wait_cnt == MEM_TIMEOUT.
- The wait counter saturates and never wraps.
- A single-cycle access (mem_req_i & mem_ready_i in the same cycle) causes no stall and no state change.
- S_FROZEN:
  - pc_stall = 1; all four modes = 2'b10; mem_timeout_o = 1.
  - Inputs are ignored, including a late mem_ready_i.
  - Only rst_ni exits this state.
- Reset asserted mid-wait aborts the wait immediately; the next cycle after release is S_RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three extra outputs exist, each CNT_W wide and cleared by reset:
  - perf_stall_cnt_o: cycles with pc_stall_o = 1
  - perf_flush_cnt_o: cycles with exe_redirect_i acted on
  - perf_luse_cnt_o: load-use cycles
- The counters saturate at all-ones and do not count while in S_FROZEN.
- When not defined, these ports and registers are absent and the behaviour above is otherwise identical.

Test Plan:
- Load x5 in EXE (rd_we = 1, mem_re = 1); ID reads rs1 = x5 -> exactly one cycle of pc_stall = 1, IF_ID = 10, ID_EXE = 01; with rd = x0 instead -> no stall.
- exe_redirect_i and load_use in the same cycle -> IF_ID = 01, ID_EXE = 01, pc_stall = 0.
- mem_req = 1 with mem_ready low for 3 cycles, then high -> 3 cycles of IF_ID/ID_EXE/EXE_MEM = 10, MEM_WB = 01, pc_stall = 1; 4th cycle all 00; state returns to S_RUN.
- With MEM_TIMEOUT = 4, mem_ready held low -> S_FROZEN after the 5th wait cycle; mem_timeout_o = 1; all modes = 10; a later mem_ready pulse is ignored; rst_ni low clears everything.
- rst_ni pulsed low during S_MEM_WAIT -> outputs all 01 immediately (asynchronously); S_RUN with wait_cnt = 0 after release.
- With HAZARD_PERF_CNT_EN: 2 load-use cycles + 3 wait cycles + 1 redirect -> stall_cnt = 5, luse_cnt = 2, flush_cnt = 1.
